// File: rtl/burst_seq_pkg.sv
// Shared types and default sizing for the burst sequencer.
package burst_seq_pkg;

    localparam int BEAT_W_DEF         = 4;
    localparam int MAX_GRANT_WAIT_DEF = 4;
    localparam int STALL_MAX_DEF      = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_MST = 3'd1,
        ST_XFER     = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERR      = 3'd4
    } burst_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_GRANT_TO = 2'd1,
        ERR_STALL    = 2'd2,
        ERR_MST_DROP = 2'd3
    } burst_err_e;

endpackage

// File: rtl/burst_seq_if.sv
// Host/master/slave handshake bundle around the burst sequencer.
interface burst_seq_if
    import burst_seq_pkg::*;
#(
    parameter int BEAT_W = BEAT_W_DEF
) ();
    logic              req;
    logic [BEAT_W-1:0] req_beats;
    logic              master_busy;
    logic              slave_busy;
    logic              err_clr;
    logic              burst_enable;
    logic              beat_valid;
    logic [BEAT_W-1:0] beat_cnt;
    logic              busy;
    logic              done;
    logic              err;
    burst_err_e        err_code;

    // Driving side: host request plus master/slave busy status.
    modport master (
        output req, req_beats, master_busy, slave_busy, err_clr,
        input  burst_enable, beat_valid, beat_cnt, busy, done, err, err_code
    );

    // Sequencer side.
    modport slave (
        input  req, req_beats, master_busy, slave_busy, err_clr,
        output burst_enable, beat_valid, beat_cnt, busy, done, err, err_code
    );
endinterface

// File: rtl/burst_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
module burst_seq_sat_cnt #(
    parameter int WIDTH = 3,
    parameter int MAX   = 4,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIMIT_V);
endmodule

// File: rtl/burst_seq_ctrl.sv
// Burst handshake sequencer: grant window, beat counting, stall/drop error reporting.
//   state    | meaning
//   IDLE     | waiting for a non-zero host request
//   WAIT_MST | burst_enable up, waiting for master_busy to drop
//   XFER     | counting beats (master and slave both not busy)
//   DONE     | one-cycle completion pulse
//   ERR      | sticky error, held until err_clr
module burst_seq_ctrl
    import burst_seq_pkg::*;
#(
    parameter int BEAT_W         = BEAT_W_DEF,
    parameter int MAX_GRANT_WAIT = MAX_GRANT_WAIT_DEF,
    parameter int STALL_MAX      = STALL_MAX_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    burst_seq_if.slave bus
);
    localparam int WAIT_W  = $clog2(MAX_GRANT_WAIT + 1);
    localparam int STALL_W = $clog2(STALL_MAX + 2);

    burst_state_e      state, state_nxt;
    burst_err_e        err_code_q, err_code_d;
    logic [BEAT_W-1:0] len_q, len_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BEAT_W-1:0] beat_cnt_inc;
    logic              beat;
    logic              wait_clr, wait_inc, wait_at_lim;
    logic              stall_clr, stall_inc, stall_at_lim;

    burst_seq_sat_cnt #(
        .WIDTH (WAIT_W),
        .MAX   (MAX_GRANT_WAIT),
        .LIMIT (MAX_GRANT_WAIT)
    ) u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (wait_clr),
        .inc      (wait_inc),
        .at_limit (wait_at_lim)
    );

    // Stall limit fires when the count already equals STALL_MAX, i.e. this stall would exceed it.
    burst_seq_sat_cnt #(
        .WIDTH (STALL_W),
        .MAX   (STALL_MAX + 1),
        .LIMIT (STALL_MAX)
    ) u_stall_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (stall_clr),
        .inc      (stall_inc),
        .at_limit (stall_at_lim)
    );

    assign beat         = (state == ST_XFER) && !bus.master_busy && !bus.slave_busy;
    assign beat_cnt_inc = beat_cnt_q + 1'b1;

    always_comb begin
        state_nxt  = state;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        err_code_d = err_code_q;
        wait_clr   = 1'b0;
        wait_inc   = 1'b0;
        stall_clr  = 1'b0;
        stall_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req && (bus.req_beats != '0)) begin
                    state_nxt  = ST_WAIT_MST;
                    len_d      = bus.req_beats;
                    beat_cnt_d = '0;
                    wait_clr   = 1'b1;
                    stall_clr  = 1'b1;
                end
            end
            ST_WAIT_MST: begin
                wait_inc = 1'b1;
                if (!bus.master_busy) begin
                    state_nxt = ST_XFER;
                end else if (wait_at_lim) begin
                    state_nxt  = ST_ERR;
                    err_code_d = ERR_GRANT_TO;
                end
            end
            ST_XFER: begin
                // Master drop wins even over a would-be final beat.
                if (bus.master_busy) begin
                    state_nxt  = ST_ERR;
                    err_code_d = ERR_MST_DROP;
                end else if (!bus.slave_busy) begin
                    beat_cnt_d = beat_cnt_inc;
                    stall_clr  = 1'b1;
                    if (beat_cnt_inc == len_q) begin
                        state_nxt = ST_DONE;
                    end
                end else begin
                    stall_inc = 1'b1;
                    if (stall_at_lim) begin
                        state_nxt  = ST_ERR;
                        err_code_d = ERR_STALL;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                if (bus.err_clr) begin
                    state_nxt  = ST_IDLE;
                    err_code_d = ERR_NONE;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state      <= state_nxt;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.burst_enable = (state == ST_WAIT_MST) || (state == ST_XFER);
    assign bus.busy         = (state != ST_IDLE);
    assign bus.done         = (state == ST_DONE);
    assign bus.err          = (state == ST_ERR);
    assign bus.err_code     = err_code_q;
    assign bus.beat_cnt     = beat_cnt_q;
    assign bus.beat_valid   = beat;
endmodule

// File: tb/tb_burst_seq_ctrl.sv
// Directed bench for burst_seq_ctrl with a per-cycle behavioural reference.
module tb_burst_seq_ctrl;
    import burst_seq_pkg::*;

    localparam int BW   = 4;
    localparam int MGW  = 4;
    localparam int SMAX = 8;

    localparam int M_IDLE  = 0;
    localparam int M_GRANT = 1;
    localparam int M_XFER  = 2;
    localparam int M_DONE  = 3;
    localparam int M_ERR   = 4;

    logic clk;
    logic rst_n;

    burst_seq_if #(.BEAT_W(BW)) bus ();

    burst_seq_ctrl #(
        .BEAT_W         (BW),
        .MAX_GRANT_WAIT (MGW),
        .STALL_MAX      (SMAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: burst phase, beats done, cycles spent waiting/stalling, error code.
    int m_mode, m_len, m_beats, m_waited, m_stalls, m_code;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE; m_len <= 0; m_beats <= 0;
            m_waited <= 0; m_stalls <= 0; m_code <= 0;
        end else begin
            case (m_mode)
                M_IDLE: if (bus.req && int'(bus.req_beats) > 0) begin
                    m_mode <= M_GRANT; m_len <= int'(bus.req_beats);
                    m_beats <= 0; m_waited <= 0; m_stalls <= 0;
                end
                M_GRANT: begin
                    if (!bus.master_busy) m_mode <= M_XFER;
                    else if (m_waited + 1 > MGW) begin m_mode <= M_ERR; m_code <= 1; end
                    m_waited <= m_waited + 1;
                end
                M_XFER: begin
                    if (bus.master_busy) begin
                        m_mode <= M_ERR; m_code <= 3;
                    end else if (!bus.slave_busy) begin
                        m_beats <= m_beats + 1; m_stalls <= 0;
                        if (m_beats + 1 == m_len) m_mode <= M_DONE;
                    end else begin
                        if (m_stalls + 1 > SMAX) begin m_mode <= M_ERR; m_code <= 2; end
                        m_stalls <= m_stalls + 1;
                    end
                end
                M_DONE: m_mode <= M_IDLE;
                M_ERR: if (bus.err_clr) begin
                    m_mode <= M_IDLE; m_code <= 0; m_beats <= 0;
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int tot_be   = 0;
    int tot_bv   = 0;
    int tot_done = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic compare_cycle();
        logic [10:0] act, exp;
        logic e_be, e_bv;
        e_be = (m_mode == M_GRANT) || (m_mode == M_XFER);
        e_bv = (m_mode == M_XFER) && !bus.master_busy && !bus.slave_busy;
        act = {bus.burst_enable, bus.beat_valid, bus.busy, bus.done, bus.err,
               bus.err_code, bus.beat_cnt};
        exp = {e_be, e_bv, (m_mode != M_IDLE), (m_mode == M_DONE), (m_mode == M_ERR),
               2'(m_code), BW'(m_beats)};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL cycle_model @%0t: got be/bv/busy/done/err/code/cnt=%b expected %b",
                      $time, act, exp);
        tot_be   += int'(bus.burst_enable);
        tot_bv   += int'(bus.beat_valid);
        tot_done += int'(bus.done);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            compare_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input int beats);
        bus.req = 1'b1; bus.req_beats = BW'(beats);
        tick();
        bus.req = 1'b0;
    endtask

    task automatic clear_err();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
    endtask

    int be0, bv0, dn0;

    task automatic snap();
        be0 = tot_be; bv0 = tot_bv; dn0 = tot_done;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req = 1'b0; bus.req_beats = '0; bus.master_busy = 1'b0;
        bus.slave_busy = 1'b0; bus.err_clr = 1'b0;
        tick(2);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_err_code", int'(bus.err_code), 0);
        rst_n = 1'b1;
        tick();

        // Async reset in the middle of a transfer
        start(5);
        tick();
        tick(2);
        chk("pre_reset_beats", int'(bus.beat_cnt), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_be", int'(bus.burst_enable), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        chk("async_rst_cnt", int'(bus.beat_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Six beats, master releases on the third grant cycle
        bus.master_busy = 1'b1;
        snap();
        start(6);
        tick(2);
        bus.master_busy = 1'b0;
        tick(8);
        chk("b6_be_cycles", tot_be - be0, 9);
        chk("b6_beats", tot_bv - bv0, 6);
        chk("b6_done", tot_done - dn0, 1);
        chk("b6_beat_cnt", int'(bus.beat_cnt), 6);

        // Grant timeout
        bus.master_busy = 1'b1;
        snap();
        start(3);
        tick(5);
        chk("gto_be_cycles", tot_be - be0, 5);
        chk("gto_err", int'(bus.err), 1);
        chk("gto_code", int'(bus.err_code), 1);
        bus.req = 1'b1; bus.req_beats = 4'd2;
        tick(2);
        bus.req = 1'b0;
        chk("gto_req_ignored", int'(bus.err_code), 1);
        clear_err();
        chk("gto_clr_err", int'(bus.err), 0);
        chk("gto_clr_code", int'(bus.err_code), 0);
        chk("gto_clr_busy", int'(bus.busy), 0);
        bus.master_busy = 1'b0;
        tick();

        // Nine stall cycles after two beats -> stall error
        start(4);
        tick(3);
        bus.slave_busy = 1'b1;
        tick(9);
        bus.slave_busy = 1'b0;
        chk("stall9_code", int'(bus.err_code), 2);
        chk("stall9_cnt", int'(bus.beat_cnt), 2);
        clear_err();

        // Eight stall cycles is tolerated
        snap();
        start(4);
        tick(3);
        bus.slave_busy = 1'b1;
        tick(8);
        bus.slave_busy = 1'b0;
        tick(3);
        chk("stall8_done", tot_done - dn0, 1);
        chk("stall8_err", int'(bus.err), 0);
        chk("stall8_cnt", int'(bus.beat_cnt), 4);

        // Master drop coincides with third beat
        snap();
        start(5);
        tick(3);
        bus.master_busy = 1'b1;
        tick();
        chk("drop_code", int'(bus.err_code), 3);
        chk("drop_cnt", int'(bus.beat_cnt), 2);
        chk("drop_beats", tot_bv - bv0, 2);
        bus.master_busy = 1'b0;
        clear_err();

        // Zero-length request, err_clr in idle, requests during XFER and DONE
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        start(0);
        tick();
        chk("zero_len_busy", int'(bus.busy), 0);
        snap();
        start(3);
        tick();
        bus.req = 1'b1; bus.req_beats = 4'd7;
        tick();
        bus.req = 1'b0;
        tick(2);
        bus.req = 1'b1; bus.req_beats = 4'd2;
        tick();
        bus.req = 1'b0;
        tick(2);
        chk("ign_done", tot_done - dn0, 1);
        chk("ign_cnt", int'(bus.beat_cnt), 3);
        chk("ign_busy", int'(bus.busy), 0);
        chk("ign_beats", tot_bv - bv0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
